// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory port arbiter: depth, address width, response owner.
// Latency: none (declarations only).
// Backpressure: not applicable.
package dmem_pkg;

  localparam int DMEM_DEPTH = 32;
  localparam int DMEM_AW    = $clog2(DMEM_DEPTH);

  // Which requester the registered response belongs to.
  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_C    = 2'd1,
    OWN_D    = 2'd2
  } owner_t;

  // Word address falls inside the physical memory.
  function automatic logic addr_in_range(input logic [31:0] addr, input int depth);
    return addr < 32'(depth);
  endfunction

endpackage

// File: rtl/dmem_port_arbiter_if.sv
// Bundle of the two requester ports (C, D) and the single-port memory side.
// Latency: none (wires only).
// Backpressure: requesters hold req and fields until gnt; memory never stalls.
interface dmem_port_arbiter_if;
  import dmem_pkg::*;

  logic        c_req;
  logic        c_we;
  logic [31:0] c_addr;
  logic [31:0] c_wdata;
  logic        c_gnt;
  logic        c_rvalid;
  logic [31:0] c_rdata;
  logic        c_err;

  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_gnt;
  logic        d_rvalid;
  logic [31:0] d_rdata;
  logic        d_err;

  logic        m_read;
  logic        m_write;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  logic [31:0] m_rdata;

  // Arbiter view.
  modport slave (
    input  c_req, c_we, c_addr, c_wdata,
    output c_gnt, c_rvalid, c_rdata, c_err,
    input  d_req, d_we, d_addr, d_wdata,
    output d_gnt, d_rvalid, d_rdata, d_err,
    output m_read, m_write, m_addr, m_wdata,
    input  m_rdata
  );

  // Requesters and memory view.
  modport master (
    output c_req, c_we, c_addr, c_wdata,
    input  c_gnt, c_rvalid, c_rdata, c_err,
    output d_req, d_we, d_addr, d_wdata,
    input  d_gnt, d_rvalid, d_rdata, d_err,
    input  m_read, m_write, m_addr, m_wdata,
    output m_rdata
  );

endinterface

// File: rtl/dmem_port_arbiter.sv
// Arbitrates CPU (C) and DMA/debug (D) onto one single-port data memory, with range check.
// Latency: grant is combinational; load/error response is one cycle after grant.
// Backpressure: losing port holds req until gnt; D is forced through after MAX_WAIT losses.
module dmem_port_arbiter
  import dmem_pkg::*;
#(
  parameter int DEPTH    = DMEM_DEPTH,
  parameter int MAX_WAIT = 4
) (
  input  logic               CLK,
  input  logic               rst_n,
  dmem_port_arbiter_if.slave bus
);

  localparam int SW = $clog2(MAX_WAIT + 1);

  logic [SW-1:0] starve_cnt;
  logic [SW-1:0] starve_nxt;
  owner_t        resp_owner;
  owner_t        owner_nxt;
  logic          resp_err;
  logic          err_nxt;

  logic          c_win;
  logic          d_win;
  logic          any_gnt;
  logic          sel_we;
  logic          sel_ok;
  logic [31:0]   sel_addr;
  logic [31:0]   sel_wdata;

  // Pick a winner (CPU first unless D has starved) and mux its fields onto the memory.
  always_comb begin
    d_win     = 1'b0;
    c_win     = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    sel_we    = 1'b0;
    if (rst_n) begin
      d_win = bus.d_req && (!bus.c_req || (starve_cnt == SW'(MAX_WAIT)));
      c_win = bus.c_req && !d_win;
    end
    if (c_win) begin
      sel_addr  = bus.c_addr;
      sel_wdata = bus.c_wdata;
      sel_we    = bus.c_we;
    end else if (d_win) begin
      sel_addr  = bus.d_addr;
      sel_wdata = bus.d_wdata;
      sel_we    = bus.d_we;
    end
    any_gnt = c_win || d_win;
    sel_ok  = addr_in_range(sel_addr, DEPTH);
  end

  assign bus.c_gnt   = c_win;
  assign bus.d_gnt   = d_win;
  assign bus.m_addr  = sel_addr;
  assign bus.m_wdata = sel_wdata;
  assign bus.m_read  = any_gnt && sel_ok && !sel_we;
  assign bus.m_write = any_gnt && sel_ok && sel_we;

  // Next starvation count and which port (if any) is owed a response next cycle.
  always_comb begin
    starve_nxt = '0;
    owner_nxt  = OWN_NONE;
    err_nxt    = 1'b0;
    if (bus.d_req && !d_win) begin
      starve_nxt = (starve_cnt == SW'(MAX_WAIT)) ? starve_cnt : starve_cnt + SW'(1);
    end
    // In-range stores complete silently; loads and any out-of-range op answer.
    if (any_gnt && !(sel_ok && sel_we)) begin
      owner_nxt = c_win ? OWN_C : OWN_D;
      err_nxt   = !sel_ok;
    end
  end

  // State registers; reset drops any response still in flight.
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt <= '0;
      resp_owner <= OWN_NONE;
      resp_err   <= 1'b0;
    end else begin
      starve_cnt <= starve_nxt;
      resp_owner <= owner_nxt;
      resp_err   <= err_nxt;
    end
  end

  // Route the memory's registered read data to the owner; error responses carry zero.
  assign bus.c_rvalid = (resp_owner == OWN_C);
  assign bus.d_rvalid = (resp_owner == OWN_D);
  assign bus.c_err    = bus.c_rvalid && resp_err;
  assign bus.d_err    = bus.d_rvalid && resp_err;
  assign bus.c_rdata  = (bus.c_rvalid && !resp_err) ? bus.m_rdata : '0;
  assign bus.d_rdata  = (bus.d_rvalid && !resp_err) ? bus.m_rdata : '0;

endmodule

// File: doc/dmem_port_arbiter.md
Name: dmem_port_arbiter

Overview:
- Shares the single-port 32x32 data memory between two requesters: the pipeline MEM stage (C) and a DMA/debug loader port (D).
- Issues at most one memory operation per cycle and routes the registered read data back to the owner.
- Sits between the MEM stage and the data memory. The CPU normally wins arbitration; a starvation counter guarantees D progress.
- Performs word-address range checking before any memory access.

Parameters:
- DEPTH, 32: number of memory words; valid word addresses are 0..DEPTH-1.
- MAX_WAIT, 4: consecutive cycles D may lose arbitration before it is forced to win.

Ports:
- CLK  in  1  system clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- c_req  in  1  CPU request; held stable with its fields until c_gnt.
- c_we  in  1  CPU op: 1 = store, 0 = load.
- c_addr  in  32  CPU word address.
- c_wdata  in  32  CPU store data.
- c_gnt  out  1  CPU request accepted this cycle (combinational).
- c_rvalid  out  1  CPU load response valid (registered).
- c_rdata  out  32  CPU load data; valid when c_rvalid.
- c_err  out  1  CPU out-of-range response; coincides with c_rvalid.
- d_req, d_we, d_addr, d_wdata, d_gnt, d_rvalid, d_rdata, d_err: same definitions and widths, for the D port.
- m_read  out  1  memory read strobe.
- m_write  out  1  memory write strobe.
- m_addr  out  32  memory word address.
- m_wdata  out  32  memory write data.
- m_rdata  in  32  memory registered read data; valid the cycle after m_read.

Behaviour:
- Reset (async, rst_n=0): starve_cnt=0, resp_owner=NONE, c_rvalid=d_rvalid=0, c_err=d_err=0. Outputs c_gnt, d_gnt, m_read, m_write are 0 because they are gated by rst_n.
- Arbitration (combinational, each cycle):
  - If only one port requests, that port is granted.
  - If both request: D is granted when starve_cnt==MAX_WAIT; otherwise C is granted.
  - At most one gnt is high in any cycle.
- starve_cnt update:
  - Increments (saturating at MAX_WAIT) when d_req=1 and d_gnt=0.
  - Clears to 0 when d_gnt=1 or d_req=0.
- Issue, in the granted cycle:
  - m_addr and m_wdata are taken from the winning port.
  - If the winner's address < DEPTH: m_write=we, m_read=~we. The two strobes are never both 1.
  - If the winner's address >= DEPTH: the grant is still given, but m_read=m_write=0 (no memory access).
  - With no grant: m_read=m_write=0, and m_addr/m_wdata hold 0.
- Response (registered, latency 1):
  - In the cycle after a granted in-range load, the winner's rvalid=1 and rdata=m_rdata (pass-through).
  - In the cycle after a granted out-of-range op (load or store), rvalid=1, err=1, rdata=0.
  - In-range stores produce no response.
  - rvalid and err are single-cycle pulses. rdata is 0 whenever rvalid=0.
- Back-to-back: a new grant may be issued in the same cycle as the previous response. This gives full throughput of 1 op/cycle.
- Write-then-read to the same address in consecutive cycles returns the new data. The memory commits the write at the first edge, so the arbiter needs no forwarding.
- Requester protocol:
  - A port may not change its req fields while req=1 and gnt=0.
  - Dropping req before grant withdraws the request. This is legal and leaves no state behind.
- Reset mid-operation: an in-flight response is discarded, with no rvalid after reset deassertion. The memory contents are not touched.

Decomposition:
- Shared package dmem_pkg:
  - DMEM_DEPTH=32 and DMEM_AW (word address width = 5).
  - Enum owner_t {OWN_NONE, OWN_C, OWN_D}.
- No sub-module. Arbitration, the starvation counter and response routing fit in one module of about 150 lines.

Test Plan:
- Reset then single CPU store: c_req=1, c_we=1, c_addr=3, c_wdata=0xDEADBEEF. Required: c_gnt=1 the same cycle, m_write=1, m_addr=3, no response. A subsequent load of address 3 gives c_rvalid=1 one cycle later with c_rdata=0xDEADBEEF.
- Contention with starvation: c_req and d_req held high continuously with loads. Required: C granted 4 cycles, then D on the 5th; starve_cnt returns to 0 and the pattern repeats.
- Out-of-range: d_req load with d_addr=40. Required: d_gnt=1, m_read=0, and the next cycle d_rvalid=1, d_err=1, d_rdata=0. Memory is unchanged, checked by reading back addresses 0..31.
- Back-to-back: C store addr 7 = 0x55 at cycle N, C load addr 7 at N+1. Required: c_rvalid at N+2 with c_rdata=0x55. Also, D load at N+2 with both grants alternating gives no lost responses.
- Async reset at a load's grant cycle: assert rst_n=0 mid-cycle. Required: all outputs 0 immediately, no rvalid after release, and the first request after release is granted normally.
- Withdrawal: d_req raised during 2 CPU-won cycles, then dropped. Required: starve_cnt=0, and no D grant or response.
